// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider.
package divider_pkg;

  // Divider control states: waiting for a request, iterating, holding a result.
  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_e;

  // Fill bit replicated across the quotient when the divisor is zero (all ones).
  localparam logic DBZ_QUOTIENT_FILL = 1'b1;

endpackage

// File: rtl/adder_subtractor.sv
// Ripple-style adder/subtractor: result = a + b (sub=0) or a - b (sub=1).
// cout is the raw carry-out, so during subtraction cout=1 means no borrow.
module adder_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  logic [WIDTH-1:0] bEff;

  // Subtraction is a + ~b + 1, so invert b and inject sub as the carry-in.
  assign bEff = b ^ {WIDTH{sub}};
  assign {cout, result} = {1'b0, a} + {1'b0, bEff} + (WIDTH+1)'(sub);
  assign overflow = (a[WIDTH-1] == bEff[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
  assign zero = (result == '0);

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider. One trial subtraction per cycle,
// one quotient bit retired per cycle, valid/ready on request and response.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_e state_q, state_d;
  logic [WIDTH:0]   partialRem_q, partialRem_d;
  logic [WIDTH-1:0] shiftQ_q, shiftQ_d;
  logic [CW-1:0]    stepCnt_q, stepCnt_d;
  logic [WIDTH-1:0] divisorReg_q, divisorReg_d;
  logic [WIDTH-1:0] quotientReg_q, quotientReg_d;
  logic [WIDTH-1:0] remainderReg_q, remainderReg_d;
  logic             dbzReg_q, dbzReg_d;

  logic [WIDTH:0]   trialA;
  logic [WIDTH:0]   trialB;
  logic [WIDTH:0]   trialResult;
  logic             trialOk;
  logic [WIDTH:0]   stepPartial;
  logic [WIDTH-1:0] stepQ;
  logic             unusedOverflow;
  logic             unusedZero;
  logic             unusedPartialMsb;

  // The partial remainder MSB is never shifted into the trial operand.
  assign unusedPartialMsb = partialRem_q[WIDTH];

  // Shift the next dividend bit into the partial remainder and trial-subtract the divisor.
  assign trialA = {partialRem_q[WIDTH-1:0], shiftQ_q[WIDTH-1]};
  assign trialB = {1'b0, divisorReg_q};

  adder_subtractor #(.WIDTH(WIDTH + 1)) u_trial (
    .a        (trialA),
    .b        (trialB),
    .sub      (1'b1),
    .result   (trialResult),
    .cout     (trialOk),
    .overflow (unusedOverflow),
    .zero     (unusedZero)
  );

  // Keep the subtraction when it did not borrow, otherwise restore the shifted value.
  assign stepPartial = trialOk ? trialResult : trialA;
  assign stepQ       = {shiftQ_q[WIDTH-2:0], trialOk};

  // Next-state, datapath updates and handshake outputs, holding everything by default.
  always_comb begin
    state_d        = state_q;
    partialRem_d   = partialRem_q;
    shiftQ_d       = shiftQ_q;
    stepCnt_d      = stepCnt_q;
    divisorReg_d   = divisorReg_q;
    quotientReg_d  = quotientReg_q;
    remainderReg_d = remainderReg_q;
    dbzReg_d       = dbzReg_q;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          divisorReg_d = divisor;
          partialRem_d = '0;
          shiftQ_d     = dividend;
          stepCnt_d    = '0;
          if (divisor == '0) begin
            quotientReg_d  = {WIDTH{DBZ_QUOTIENT_FILL}};
            remainderReg_d = dividend;
            dbzReg_d       = 1'b1;
            state_d        = DIV_DONE;
          end else begin
            state_d = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        partialRem_d = stepPartial;
        shiftQ_d     = stepQ;
        stepCnt_d    = stepCnt_q + CW'(1);
        if (stepCnt_q == LAST_STEP) begin
          quotientReg_d  = stepQ;
          remainderReg_d = stepPartial[WIDTH-1:0];
          dbzReg_d       = 1'b0;
          state_d        = DIV_DONE;
        end
      end
      DIV_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = DIV_IDLE;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset overrides any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= DIV_IDLE;
      partialRem_q   <= '0;
      shiftQ_q       <= '0;
      stepCnt_q      <= '0;
      divisorReg_q   <= '0;
      quotientReg_q  <= '0;
      remainderReg_q <= '0;
      dbzReg_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      partialRem_q   <= partialRem_d;
      shiftQ_q       <= shiftQ_d;
      stepCnt_q      <= stepCnt_d;
      divisorReg_q   <= divisorReg_d;
      quotientReg_q  <= quotientReg_d;
      remainderReg_q <= remainderReg_d;
      dbzReg_q       <= dbzReg_d;
    end
  end

  assign quotient    = quotientReg_q;
  assign remainder   = remainderReg_q;
  assign div_by_zero = dbzReg_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and randomized self-checking bench for the 8-bit restoring divider.
module tb_restoring_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int failures = 0;

  restoring_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Present one request, handshake it, then count cycles until rsp_valid (bounded).
  task automatic applyStimulus(input logic [7:0] n, input logic [7:0] d, output int lat);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL req_ready_wait: got %b expected 1", req_ready);
    end
    req_valid = 1'b1;
    dividend  = n;
    divisor   = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    dividend  = '0;
    divisor   = '0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rsp_timeout %0d/%0d: got rsp_valid=%b expected 1", n, d, rsp_valid);
    end
  endtask

  // Accept the pending response with a one-cycle rsp_ready pulse.
  task automatic completeResponse();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++;
    if (quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got q=%0d r=%0d dbz=%b expected 0 0 0", quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    applyStimulus(8'd100, 8'd7, lat);
    checks++;
    if (lat !== 9) begin failures++; $display("[TB] FAIL basic_latency: got %0d expected 9", lat); end
    checks++;
    if (quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_100_7: got q=%0d r=%0d dbz=%b expected 14 2 0", quotient, remainder, div_by_zero);
    end
    completeResponse();
  endtask

  task automatic test_div_zero();
    int lat;
    applyStimulus(8'd5, 8'd0, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("[TB] FAIL dbz_latency: got %0d expected 1", lat); end
    checks++;
    if (quotient !== 8'd255 || remainder !== 8'd5 || div_by_zero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL dbz_5_0: got q=%0d r=%0d dbz=%b expected 255 5 1", quotient, remainder, div_by_zero);
    end
    completeResponse();
    applyStimulus(8'd255, 8'd1, lat);
    checks++;
    if (quotient !== 8'd255 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL div_255_1: got q=%0d r=%0d dbz=%b expected 255 0 0", quotient, remainder, div_by_zero);
    end
    completeResponse();
  endtask

  task automatic test_boundaries();
    logic [7:0] nTab[3] = '{8'd3, 8'd0, 8'd255};
    logic [7:0] dTab[3] = '{8'd10, 8'd9, 8'd255};
    logic [7:0] qTab[3] = '{8'd0, 8'd0, 8'd1};
    logic [7:0] rTab[3] = '{8'd3, 8'd0, 8'd0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(nTab[i], dTab[i], lat);
      checks++;
      if (quotient !== qTab[i] || remainder !== rTab[i] || div_by_zero !== 1'b0) begin
        failures++;
        $display("[TB] FAIL boundary_%0d_%0d: got q=%0d r=%0d dbz=%b expected %0d %0d 0",
                 nTab[i], dTab[i], quotient, remainder, div_by_zero, qTab[i], rTab[i]);
      end
      checks++;
      if (lat !== 9) begin failures++; $display("[TB] FAIL boundary_latency_%0d: got %0d expected 9", i, lat); end
      completeResponse();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    applyStimulus(8'd37, 8'd5, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || quotient !== 8'd7 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
        failures++;
        $display("[TB] FAIL hold_cycle_%0d: got v=%b rdy=%b q=%0d r=%0d dbz=%b expected 1 0 7 2 0",
                 i, rsp_valid, req_ready, quotient, remainder, div_by_zero);
      end
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    dividend  = 8'd9;
    divisor   = 8'd4;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL after_rsp_handshake: got rdy=%b v=%b expected 1 0", req_ready, rsp_valid);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL next_req_accept: got rdy=%b expected 0", req_ready);
    end
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 9 || quotient !== 8'd2 || remainder !== 8'd1) begin
      failures++;
      $display("[TB] FAIL followup_9_4: got lat=%0d q=%0d r=%0d expected 9 2 1", lat, quotient, remainder);
    end
    completeResponse();
  endtask

  task automatic test_reset_midrun();
    int lat;
    @(negedge clk);
    req_valid = 1'b1;
    dividend  = 8'd200;
    divisor   = 8'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrun_reset: got rdy=%b v=%b q=%0d r=%0d dbz=%b expected 1 0 0 0 0",
               req_ready, rsp_valid, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b1;
    dividend  = 8'd50;
    divisor   = 8'd5;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_beats_handshake: got rdy=%b v=%b expected 1 0", req_ready, rsp_valid);
    end
    applyStimulus(8'd200, 8'd3, lat);
    checks++;
    if (quotient !== 8'd66 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL after_reset_200_3: got q=%0d r=%0d dbz=%b expected 66 2 0", quotient, remainder, div_by_zero);
    end
    completeResponse();
  endtask

  task automatic test_random();
    logic [7:0] n;
    logic [7:0] d;
    logic [7:0] expQ;
    logic [7:0] expR;
    logic       expZ;
    int lat;
    for (int i = 0; i < 300; i++) begin
      n = 8'($urandom_range(0, 255));
      d = (i % 16 == 5) ? 8'd0 : 8'($urandom_range(0, 255));
      if (d == 8'd0) begin
        expQ = 8'hFF;
        expR = n;
        expZ = 1'b1;
      end else begin
        expQ = n / d;
        expR = n % d;
        expZ = 1'b0;
      end
      applyStimulus(n, d, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      checks++;
      if (quotient !== expQ || remainder !== expR || div_by_zero !== expZ) begin
        failures++;
        $display("[TB] FAIL random_%0d_%0d: got q=%0d r=%0d dbz=%b expected %0d %0d %b",
                 n, d, quotient, remainder, div_by_zero, expQ, expR, expZ);
      end
      completeResponse();
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_boundaries();
    test_backpressure();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
